// File: rtl/ks_pkg.sv
// Shared Kogge-Stone definitions: operand width, prefix depth, and the
// black-cell combine plus the per-level operand shift used by the prefix tree.
package ks_pkg;

  localparam int KS_W      = 16;
  localparam int KS_LEVELS = 4;

  typedef struct packed {
    logic [KS_W-1:0] p;
    logic [KS_W-1:0] g;
  } pg_t;

  // Black cell applied across the whole vector: hi is bit i, lo is bit i-span.
  function automatic pg_t ks_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Lanes below the span see zero, so already-resolved positions keep their G.
  function automatic pg_t ks_shift(input pg_t x, input int span);
    pg_t r;
    r.g = x.g << span;
    r.p = x.p << span;
    return r;
  endfunction

endpackage

// File: rtl/ks_pipe_stage.sv
// Valid/ready register slice: 1 cycle; loads when empty or when downstream
// loads. Data is written only for real transfers, so it holds the last value.
module ks_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         down_load,
  output logic         load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  assign load = ~out_valid | down_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ks_sub16_pipe.sv
// 16-bit Kogge-Stone subtractor d = a + ~b + 1; 2-cycle latency, 1/cycle, stalls
// by out_ready with 2 in flight. KS_SUB_OVF_EN adds the registered signed ovf output.
module ks_sub16_pipe
  import ks_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [KS_W-1:0] a,
  input  logic [KS_W-1:0] b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [KS_W-1:0] d,
  output logic            borrow,
  output logic            out_valid,
  input  logic            out_ready
`ifdef KS_SUB_OVF_EN
  ,
  output logic            ovf
`endif
);

  typedef struct packed {
    pg_t             grp;
    logic [KS_W-1:0] p;
`ifdef KS_SUB_OVF_EN
    logic            a_sign;
    logic            b_sign;
`endif
  } s1_t;

  typedef struct packed {
    logic [KS_W-1:0] d;
    logic            borrow;
`ifdef KS_SUB_OVF_EN
    logic            ovf;
`endif
  } s2_t;

  s1_t  s1_n, s1_q;
  s2_t  s2_n, s2_q;
  pg_t  s1_pg, s2_pg;
  logic s1_valid, s1_load, s2_load;
  logic [KS_W-1:0] carry;

  // Carry-in of 1 is absorbed into bit 0's generate, so G[i] is the carry out of bit i.
  always_comb begin
    s1_pg.p    = a ^ ~b;
    s1_pg.g    = a & ~b;
    s1_pg.g[0] = s1_pg.g[0] | s1_pg.p[0];
    for (int l = 0; l < KS_LEVELS / 2; l++) begin
      s1_pg = ks_combine(s1_pg, ks_shift(s1_pg, 1 << l));
    end
    s1_n.grp = s1_pg;
    s1_n.p   = a ^ ~b;
`ifdef KS_SUB_OVF_EN
    s1_n.a_sign = a[KS_W-1];
    s1_n.b_sign = b[KS_W-1];
`endif
  end

  ks_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (s1_n),
    .down_load (s2_load),
    .load      (s1_load),
    .out_valid (s1_valid),
    .out_data  (s1_q)
  );

  always_comb begin
    s2_pg = s1_q.grp;
    for (int l = KS_LEVELS / 2; l < KS_LEVELS; l++) begin
      s2_pg = ks_combine(s2_pg, ks_shift(s2_pg, 1 << l));
    end
    carry     = {s2_pg.g[KS_W-2:0], 1'b1};
    s2_n.d      = s1_q.p ^ carry;
    s2_n.borrow = ~s2_pg.g[KS_W-1];
`ifdef KS_SUB_OVF_EN
    s2_n.ovf = (s1_q.a_sign ^ s1_q.b_sign) & (s1_q.a_sign ^ s2_n.d[KS_W-1]);
`endif
  end

  ks_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_data   (s2_n),
    .down_load (out_ready),
    .load      (s2_load),
    .out_valid (out_valid),
    .out_data  (s2_q)
  );

  // Reset empties both stages, which would otherwise advertise space.
  assign in_ready = s1_load & rst_n;
  assign d        = s2_q.d;
  assign borrow   = s2_q.borrow;
`ifdef KS_SUB_OVF_EN
  assign ovf      = s2_q.ovf;
`endif

endmodule
